// File: rtl/snake_control.sv
// rtl/snake_control.sv - snake head step sequencer with direction filter and VGA write alignment
module snake_control #(
  parameter int          FRAME_DIV       = 833333,
  parameter int          FRAMES_PER_STEP = 15,
  parameter logic [2:0]  SNAKE_COLOUR    = 3'b010,
  parameter logic [2:0]  BG_COLOUR       = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic       ld,
  output logic       update,
  output logic       plot,
  output logic [2:0] dir,
  output logic       vga_we,
  output logic [2:0] colour,
  output logic [2:0] state_o
);

  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int SW = (FRAMES_PER_STEP > 0) ? $clog2(FRAMES_PER_STEP + 1) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(FRAMES_PER_STEP - 1);

  localparam logic [2:0] DIR_UP    = 3'b100;
  localparam logic [2:0] DIR_DOWN  = 3'b110;
  localparam logic [2:0] DIR_LEFT  = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAW   = 3'd2,
    S_WAIT   = 3'd3,
    S_ERASE  = 3'd4,
    S_UPDATE = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [1:0]    pix_cnt;
  logic [FW-1:0] frame_cnt;
  logic [SW-1:0] step_cnt;
  logic [2:0]    pend_dir;
  logic [2:0]    key_dir;
  logic [2:0]    dir_eff;
  logic          key_any;
  logic          frame_tick;
  logic          commit;

  function automatic logic [2:0] reverse_of(input logic [2:0] d);
    case (d)
      DIR_UP:   reverse_of = DIR_DOWN;
      DIR_DOWN: reverse_of = DIR_UP;
      DIR_LEFT: reverse_of = DIR_RIGHT;
      default:  reverse_of = DIR_LEFT;
    endcase
  endfunction

  assign frame_tick = (state == S_WAIT) && (frame_cnt == FRAME_LAST);
  assign commit     = (state == S_ERASE) && (pix_cnt == 2'd3);
  assign state_o    = state;

  always_comb begin
    state_next = state;
    ld         = 1'b0;
    update     = 1'b0;
    plot       = 1'b0;
    case (state)
      S_IDLE:   if (go) state_next = S_LOAD;
      S_LOAD: begin
        ld         = 1'b1;
        state_next = S_DRAW;
      end
      S_DRAW: begin
        plot = 1'b1;
        if (pix_cnt == 2'd3) state_next = S_WAIT;
      end
      S_WAIT:   if (frame_tick && (step_cnt == STEP_LAST)) state_next = S_ERASE;
      S_ERASE: begin
        plot = 1'b1;
        if (pix_cnt == 2'd3) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        update     = 1'b1;
        state_next = S_DRAW;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Reverse check is against the direction in force after this edge, so a
  // key landing on the commit cycle cannot queue a reversal of the new heading.
  always_comb begin
    key_any = key_up | key_down | key_left | key_right;
    if (key_up)        key_dir = DIR_UP;
    else if (key_down) key_dir = DIR_DOWN;
    else if (key_left) key_dir = DIR_LEFT;
    else               key_dir = DIR_RIGHT;
    dir_eff = commit ? pend_dir : dir;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pix_cnt   <= '0;
      frame_cnt <= '0;
      step_cnt  <= '0;
      dir       <= DIR_RIGHT;
      pend_dir  <= DIR_RIGHT;
      vga_we    <= 1'b0;
      colour    <= BG_COLOUR;
    end else begin
      state   <= state_next;
      pix_cnt <= ((state == S_DRAW) || (state == S_ERASE)) ? pix_cnt + 2'd1 : 2'd0;
      if (state == S_WAIT) begin
        frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;
        if (frame_tick) step_cnt <= step_cnt + 1'b1;
      end else begin
        frame_cnt <= '0;
        step_cnt  <= '0;
      end
      if (commit) dir <= pend_dir;
      if ((state != S_IDLE) && key_any && (key_dir != reverse_of(dir_eff)))
        pend_dir <= key_dir;
      vga_we <= plot;
      colour <= (state == S_DRAW) ? SNAKE_COLOUR : BG_COLOUR;
    end
  end

endmodule
